// File: rtl/lcd_pkg.sv
// Shared definitions for the 4-bit character LCD write path: FSM encodings,
// default timing, the fixed configuration ROM and command codes.
package lcd_pkg;

  typedef enum logic [3:0] {
    ST_WAIT_INIT,
    ST_CFG_LOAD,
    ST_SETUP_HI,
    ST_PULSE_HI,
    ST_GAP,
    ST_SETUP_LO,
    ST_PULSE_LO,
    ST_WAIT,
    ST_READY
  } lcd_state_e;

  typedef enum logic [1:0] {
    NW_IDLE,
    NW_SETUP,
    NW_PULSE
  } nw_phase_e;

  // Defaults assume a 50 MHz clock
  localparam int unsigned SETUP_CYCLES_DEF = 2;
  localparam int unsigned PULSE_CYCLES_DEF = 12;
  localparam int unsigned NIBBLE_GAP_DEF   = 50;
  localparam int unsigned BYTE_WAIT_DEF    = 2000;
  localparam int unsigned CLEAR_WAIT_DEF   = 82000;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  localparam logic [1:0] CFG_LAST_IDX = 2'd3;

  function automatic logic [7:0] cfg_rom(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h28;  // function set: 4-bit, 2 lines, 5x8
      2'd1:    b = 8'h06;  // entry mode: increment, no shift
      2'd2:    b = 8'h0C;  // display on, cursor off
      default: b = CMD_CLEAR;
    endcase
    return b;
  endfunction

  function automatic logic is_long_cmd(input logic is_data, input logic [7:0] b);
    return !is_data && ((b == CMD_CLEAR) || (b == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one LCD nibble: RS/data set up for SETUP_CYCLES, then E high for
// exactly PULSE_CYCLES. RS/data are held after the pulse until the next start.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = SETUP_CYCLES_DEF,
  parameter int unsigned PULSE_CYCLES = PULSE_CYCLES_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] nibble_i,
  input  logic       rs_i,
  output logic       e_o,
  output logic       rs_o,
  output logic [3:0] data_o,
  output logic       setup_done_o,
  output logic       done_o
);

  localparam int unsigned NW_MAX = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int unsigned NW_W   = $clog2(NW_MAX + 1);

  nw_phase_e       phase_q, phase_d;
  logic [NW_W-1:0] cnt_q, cnt_d;
  logic            e_q, e_d;
  logic            rs_q, rs_d;
  logic [3:0]      data_q, data_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= NW_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    phase_d      = phase_q;
    cnt_d        = cnt_q + NW_W'(1);
    e_d          = e_q;
    rs_d         = rs_q;
    data_d       = data_q;
    setup_done_o = 1'b0;
    done_o       = 1'b0;

    case (phase_q)
      NW_SETUP: begin
        if (cnt_q == NW_W'(SETUP_CYCLES - 1)) begin
          phase_d      = NW_PULSE;
          cnt_d        = '0;
          e_d          = 1'b1;
          setup_done_o = 1'b1;
        end
      end
      NW_PULSE: begin
        if (cnt_q == NW_W'(PULSE_CYCLES - 1)) begin
          phase_d = NW_IDLE;
          cnt_d   = '0;
          e_d     = 1'b0;
          done_o  = 1'b1;
        end
      end
      default: begin
        phase_d = NW_IDLE;
        cnt_d   = '0;
      end
    endcase

    // RS/data only ever change here, while E is low
    if (start_i) begin
      phase_d = NW_SETUP;
      cnt_d   = '0;
      e_d     = 1'b0;
      rs_d    = rs_i;
      data_d  = nibble_i;
    end
  end

  assign e_o    = e_q;
  assign rs_o   = rs_q;
  assign data_o = data_q;

endmodule

// File: rtl/lcd_write_sequencer.sv
// Post-init LCD write sequencer: replays the configuration bytes, then accepts
// command/data bytes on valid/ready and emits each as two timed nibble writes.
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = SETUP_CYCLES_DEF,
  parameter int unsigned PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int unsigned NIBBLE_GAP   = NIBBLE_GAP_DEF,
  parameter int unsigned BYTE_WAIT    = BYTE_WAIT_DEF,
  parameter int unsigned CLEAR_WAIT   = CLEAR_WAIT_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iInitDone,
  input  logic       iWrite_Valid,
  input  logic       iWrite_IsData,
  input  logic [7:0] iWrite_Byte,
  output logic       oWrite_Ready,
  output logic       oConfigDone,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic [3:0] oLCD_Data
);

  localparam int unsigned CNT_W = $clog2(CLEAR_WAIT + 1);

  lcd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cfg_idx_q, cfg_idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             isdata_q, isdata_d;
  logic             ready_q, ready_d;
  logic             cfg_done_q, cfg_done_d;

  logic             nw_start;
  logic [3:0]       nw_nibble;
  logic             nw_rs;
  logic             nw_setup_done;
  logic             nw_done;
  logic [CNT_W-1:0] wait_last;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_WAIT_INIT;
      cnt_q      <= '0;
      cfg_idx_q  <= '0;
      byte_q     <= '0;
      isdata_q   <= 1'b0;
      ready_q    <= 1'b0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_idx_q  <= cfg_idx_d;
      byte_q     <= byte_d;
      isdata_q   <= isdata_d;
      ready_q    <= ready_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cfg_idx_d  = cfg_idx_q;
    byte_d     = byte_q;
    isdata_d   = isdata_q;
    cfg_done_d = cfg_done_q;
    wait_last  = is_long_cmd(isdata_q, byte_q) ? CNT_W'(CLEAR_WAIT - 1)
                                               : CNT_W'(BYTE_WAIT - 1);

    case (state_q)
      ST_WAIT_INIT: if (iInitDone) state_d = ST_CFG_LOAD;
      ST_CFG_LOAD: begin
        byte_d   = cfg_rom(cfg_idx_q);
        isdata_d = 1'b0;
        state_d  = ST_SETUP_HI;
      end
      ST_READY: begin
        if (iWrite_Valid && ready_q) begin
          byte_d   = iWrite_Byte;
          isdata_d = iWrite_IsData;
          state_d  = ST_SETUP_HI;
        end
      end
      ST_SETUP_HI: if (nw_setup_done) state_d = ST_PULSE_HI;
      ST_PULSE_HI: if (nw_done) state_d = ST_GAP;
      ST_GAP:      if (cnt_q == CNT_W'(NIBBLE_GAP - 1)) state_d = ST_SETUP_LO;
      ST_SETUP_LO: if (nw_setup_done) state_d = ST_PULSE_LO;
      ST_PULSE_LO: if (nw_done) state_d = ST_WAIT;
      ST_WAIT: begin
        if (cnt_q == wait_last) begin
          if (cfg_done_q) begin
            state_d = ST_READY;
          end else if (cfg_idx_q == CFG_LAST_IDX) begin
            cfg_done_d = 1'b1;
            state_d    = ST_READY;
          end else begin
            cfg_idx_d = cfg_idx_q + 2'd1;
            state_d   = ST_CFG_LOAD;
          end
        end
      end
      default: state_d = ST_WAIT_INIT;
    endcase
  end

  // Counter restarts on every state change and only advances in GAP/WAIT, so it cannot wrap
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == ST_GAP) || (state_q == ST_WAIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // The writer is launched on the same edge the setup state is entered, so
  // setup time is measured from that edge and the accepted byte goes out directly.
  always_comb begin
    nw_start  = 1'b0;
    nw_nibble = byte_q[3:0];
    nw_rs     = isdata_q;
    if (state_d != state_q) begin
      if (state_d == ST_SETUP_HI) begin
        nw_start  = 1'b1;
        nw_nibble = byte_d[7:4];
        nw_rs     = isdata_d;
      end else if (state_d == ST_SETUP_LO) begin
        nw_start  = 1'b1;
        nw_nibble = byte_q[3:0];
        nw_rs     = isdata_q;
      end
    end
  end

  assign ready_d = (state_d == ST_READY);

  lcd_nibble_writer #(
    .SETUP_CYCLES(SETUP_CYCLES),
    .PULSE_CYCLES(PULSE_CYCLES)
  ) u_nibble_writer (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .start_i      (nw_start),
    .nibble_i     (nw_nibble),
    .rs_i         (nw_rs),
    .e_o          (oLCD_Enabled),
    .rs_o         (oLCD_RegisterSelect),
    .data_o       (oLCD_Data),
    .setup_done_o (nw_setup_done),
    .done_o       (nw_done)
  );

  assign oWrite_Ready   = ready_q;
  assign oConfigDone    = cfg_done_q;
  assign oLCD_ReadWrite = 1'b0;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Scoreboard bench for lcd_write_sequencer: stimulus queues expected nibbles and
// waits; a negedge monitor checks every E pulse and ready rise against them.
module tb_lcd_write_sequencer;

  localparam int SU = 2;
  localparam int PW = 12;
  localparam int NG = 50;
  localparam int BW = 2000;
  localparam int CW = 5000;
  localparam int BYTE_LAT = 1 + 2*SU + 2*PW + NG + BW;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iInitDone;
  logic       iWrite_Valid;
  logic       iWrite_IsData;
  logic [7:0] iWrite_Byte;
  logic       oWrite_Ready;
  logic       oConfigDone;
  logic       oLCD_Enabled;
  logic       oLCD_RegisterSelect;
  logic       oLCD_ReadWrite;
  logic [3:0] oLCD_Data;

  lcd_write_sequencer #(
    .SETUP_CYCLES(SU),
    .PULSE_CYCLES(PW),
    .NIBBLE_GAP  (NG),
    .BYTE_WAIT   (BW),
    .CLEAR_WAIT  (CW)
  ) dut (
    .Clock              (Clock),
    .Reset              (Reset),
    .iInitDone          (iInitDone),
    .iWrite_Valid       (iWrite_Valid),
    .iWrite_IsData      (iWrite_IsData),
    .iWrite_Byte        (iWrite_Byte),
    .oWrite_Ready       (oWrite_Ready),
    .oConfigDone        (oConfigDone),
    .oLCD_Enabled       (oLCD_Enabled),
    .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_ReadWrite     (oLCD_ReadWrite),
    .oLCD_Data          (oLCD_Data)
  );

  always #10 Clock = ~Clock;

  typedef struct packed {
    logic       rs;
    logic [3:0] d;
  } nib_t;

  nib_t exp_nib[$];
  int   exp_wait[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic       prev_e = 1'b0, prev_rdy = 1'b0, unstable = 1'b0, cap_rs = 1'b0;
  logic [3:0] cap_d = '0;
  int         rise_cyc = 0, last_fall = 0, nib_idx = 0;

  always @(negedge Clock) begin
    nib_t e;
    int   w;
    cyc++;
    if (Reset) begin
      prev_e   = 1'b0;
      prev_rdy = 1'b0;
      nib_idx  = 0;
    end else begin
      if (oLCD_Enabled && !prev_e) begin
        rise_cyc = cyc;
        cap_rs   = oLCD_RegisterSelect;
        cap_d    = oLCD_Data;
        unstable = 1'b0;
        check("nibble_expected", exp_nib.size() > 0, 1);
        if (exp_nib.size() > 0) begin
          e = exp_nib.pop_front();
          check("nibble_rs", oLCD_RegisterSelect, e.rs);
          check("nibble_data", oLCD_Data, e.d);
        end
        check("rw_low", oLCD_ReadWrite, 0);
        if (nib_idx == 1) check("nibble_gap", cyc - last_fall, NG + SU);
      end
      if (oLCD_Enabled && prev_e &&
          ((oLCD_RegisterSelect !== cap_rs) || (oLCD_Data !== cap_d))) unstable = 1'b1;
      if (!oLCD_Enabled && prev_e) begin
        check("e_width", cyc - rise_cyc, PW);
        check("rs_data_stable_during_e", unstable, 0);
        last_fall = cyc;
        nib_idx   = 1 - nib_idx;
      end
      if (oWrite_Ready && !prev_rdy) begin
        check("ready_expected", exp_wait.size() > 0, 1);
        if (exp_wait.size() > 0) begin
          w = exp_wait.pop_front();
          check("ready_after_e_fall", cyc - last_fall, w);
        end
        check("ready_on_byte_boundary", nib_idx, 0);
      end
      prev_e   = oLCD_Enabled;
      prev_rdy = oWrite_Ready;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push_byte(input logic [7:0] b, input logic d);
    exp_nib.push_back('{rs: d, d: b[7:4]});
    exp_nib.push_back('{rs: d, d: b[3:0]});
  endtask

  task automatic push_config();
    push_byte(8'h28, 1'b0);
    push_byte(8'h06, 1'b0);
    push_byte(8'h0C, 1'b0);
    push_byte(8'h01, 1'b0);
    exp_wait.push_back(CW);
  endtask

  task automatic wait_config(input string name);
    int n = 0;
    while (!oConfigDone && n < 30000) begin
      @(negedge Clock);
      n++;
    end
    check({name, "_config_done"}, oConfigDone, 1);
    check({name, "_ready_with_config_done"}, oWrite_Ready, 1);
    check({name, "_config_nibbles_consumed"}, exp_nib.size(), 0);
  endtask

  // Presents a byte and returns the monitor cycle of the accepting edge; valid stays high.
  task automatic send(input logic [7:0] b, input logic d, output int acc);
    int n = 0;
    push_byte(b, d);
    exp_wait.push_back((!d && (b == 8'h01 || b == 8'h02)) ? CW : BW);
    @(negedge Clock);
    iWrite_Valid  = 1'b1;
    iWrite_Byte   = b;
    iWrite_IsData = d;
    while (!oWrite_Ready && n < 20000) begin
      @(negedge Clock);
      n++;
    end
    check("accept_within_budget", oWrite_Ready, 1);
    @(posedge Clock);
    #1;
    acc = cyc;
  endtask

  task automatic drop_valid();
    @(negedge Clock);
    iWrite_Valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!oWrite_Ready && n < 20000) begin
      @(negedge Clock);
      n++;
    end
    check({name, "_ready_returned"}, oWrite_Ready, 1);
  endtask

  initial begin
    int t1, t2, n;
    Reset         = 1'b1;
    iInitDone     = 1'b0;
    iWrite_Valid  = 1'b0;
    iWrite_IsData = 1'b0;
    iWrite_Byte   = '0;
    repeat (5) @(posedge Clock);
    #1;
    check("rst_e", oLCD_Enabled, 0);
    check("rst_rs", oLCD_RegisterSelect, 0);
    check("rst_data", oLCD_Data, 0);
    check("rst_ready", oWrite_Ready, 0);
    check("rst_config_done", oConfigDone, 0);
    check("rst_rw", oLCD_ReadWrite, 0);

    // configuration sequence
    push_config();
    @(negedge Clock);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);
    check("idle_before_init_e", oLCD_Enabled, 0);
    iInitDone = 1'b1;
    wait_config("cfg1");

    // data 0x41, with a valid pulse while busy that must be ignored
    send(8'h41, 1'b1, t1);
    drop_valid();
    repeat (100) @(negedge Clock);
    check("busy_ready_low", oWrite_Ready, 0);
    iWrite_Valid  = 1'b1;
    iWrite_Byte   = 8'h55;
    iWrite_IsData = 1'b1;
    @(negedge Clock);
    iWrite_Valid = 1'b0;
    wait_ready("data41");

    // clear, home, and data 0x01 (data must not use the long wait)
    send(8'h01, 1'b0, t1);
    drop_valid();
    wait_ready("cmd01");
    send(8'h02, 1'b0, t1);
    drop_valid();
    wait_ready("cmd02");
    send(8'h01, 1'b1, t1);
    drop_valid();
    wait_ready("data01");

    // valid held across two bytes
    send(8'h48, 1'b1, t1);
    send(8'h49, 1'b1, t2);
    check("back_to_back_accept_spacing", t2 - t1, BYTE_LAT);
    drop_valid();
    wait_ready("held");
    check("all_nibbles_consumed", exp_nib.size(), 0);

    // reset during the high-nibble pulse
    send(8'h33, 1'b1, t1);
    drop_valid();
    n = 0;
    while (!oLCD_Enabled && n < 100) begin
      @(negedge Clock);
      n++;
    end
    check("pulse_started", oLCD_Enabled, 1);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    check("midrst_e", oLCD_Enabled, 0);
    check("midrst_ready", oWrite_Ready, 0);
    check("midrst_config_done", oConfigDone, 0);
    exp_nib.delete();
    exp_wait.delete();
    push_config();
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    wait_config("cfg2");

    repeat (20) @(negedge Clock);
    check("final_waits_consumed", exp_wait.size(), 0);
    check("final_nibbles_consumed", exp_nib.size(), 0);
    check("final_idle_e", oLCD_Enabled, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
